// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divider, TX sequencer state
// encoding and frame geometry. Imported by uart_tx_arbiter and
// uart_tx_shifter.
package uart_pkg;

  localparam int unsigned UART_BAUD_DIV_DEFAULT = 10416;  // 9600 baud @ 100 MHz
  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_FRAME_BITS       = 10;     // start + 8 data + stop

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// UART TX datapath: baud counter, bit index counter, shift register and
// the registered TX pin. Sequenced by the arbiter's FSM state.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : accept pulse; latches data and starts the start bit
//   data      : byte to transmit
//   state     : current FSM state from the arbiter
//   bit_tick  : last cycle of the current bit period
//   last_bit  : bit index is at the final data bit
//   done      : last cycle of the stop bit (frame complete)
//   tx        : UART TX pin, idle high
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] data,
  input  uart_state_e               state,
  output logic                      bit_tick,
  output logic                      last_bit,
  output logic                      done,
  output logic                      tx
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);

  logic [CW-1:0]               baud_cnt_q, baud_cnt_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        tx_q, tx_d;

  always_comb begin
    bit_tick   = (state != ST_IDLE) && (baud_cnt_q == BAUD_MAX);
    last_bit   = (bit_cnt_q == 3'(UART_DATA_BITS - 1));
    done       = bit_tick && (state == ST_STOP);
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    if (load) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = data;
      tx_d       = 1'b0;
    end else if (state != ST_IDLE) begin
      baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
      // TX is loaded with the next bit's level at the boundary so the pin
      // changes exactly on the bit edge from a flop.
      if (bit_tick) begin
        case (state)
          ST_START: tx_d = shift_q[0];
          ST_DATA: begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = last_bit ? 1'b1 : shift_q[1];
          end
          default: tx_d = 1'b1;
        endcase
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single UART transmitter.
//   clk, rst               : clock, asynchronous active-high reset
//   req0_valid/data/ready  : requester 0 (CPU store path) handshake
//   req1_valid/data/ready  : requester 1 (RX echo/debug path) handshake
//   uart_tx_serial_output  : UART TX pin, idle high
//   busy                   : a frame is in progress
//   grant_id               : requester being served, or last served
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx_serial_output,
  output logic       busy,
  output logic       grant_id
);

  uart_state_e state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic        winner, accept;
  logic        bit_tick, last_bit, done;
  logic [7:0]  load_data;

  always_comb begin
    // On a tie the requester that did not win last time goes next.
    winner       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept       = (state_q == ST_IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready   = accept && !winner;
    req1_ready   = accept && winner;
    load_data    = winner ? req1_data : req0_data;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d      = ST_START;
        last_grant_d = winner;
        grant_id_d   = winner;
      end
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA:  if (bit_tick && last_bit) state_d = ST_STOP;
      ST_STOP:  if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  uart_tx_shifter #(.BAUD_DIV(BAUD_DIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .data     (load_data),
    .state    (state_q),
    .bit_tick (bit_tick),
    .last_bit (last_bit),
    .done     (done),
    .tx       (uart_tx_serial_output)
  );

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;

endmodule
